addsub_serial_unit: RTL and testbench
=====================================

ADDSUB_SERIAL_UNIT -- requirements
Module: addsub_serial_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK >= 1.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 a, b  input  WIDTH  operands, sampled on accept.
REQ-006 c_in  input  1  carry-in, sampled on accept.
REQ-007 op  input  1  0 = add, 1 = subtract; sampled on accept.
REQ-008 rev  input  1  1 = swap operands, x=b and y=a; 0 gives x=a and y=b. Sampled on accept.
REQ-009 use_cflag  input  1  take carry-in from the stored C flag; sampled on accept; see REQ-024.
REQ-010 in_valid / in_ready  input / output  1  request handshake.
REQ-011 out_valid / out_ready  output / input  1  result handshake.
REQ-012 s  output  WIDTH  result.
REQ-013 n, z, c, v  output  1 each  negative, zero, carry, and signed-overflow flags of s.

Function
REQ-014 The block SHALL compute s = x + y + cin for add and s = x + ~y + cin for subtract, with cin = c_in (ARM convention: subtract with cin=1 means no borrow).
REQ-015 Flag definitions:
- n = s[WIDTH-1].
- z = (s == 0).
- c = carry out of bit WIDTH-1.
- v = carry into MSB XOR carry out of MSB.
REQ-016 FSM states and transitions:
- IDLE -> BUSY on in_valid && in_ready.
- BUSY -> DONE after N cycles.
- DONE -> IDLE on out_valid && out_ready.
REQ-017 in_ready SHALL be 1 exactly when the state is IDLE; in_valid SHALL be ignored in BUSY and DONE.
REQ-018 BUSY SHALL process chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) in cycle k, k = 0..N-1, LSB chunk first, with a registered inter-chunk carry.
REQ-019 out_valid SHALL rise at the N-th rising edge after the accept edge; with N=1, s is valid one cycle after accept.
REQ-020 While out_valid=1 and out_ready=0, s, n, z, c and v SHALL hold stable.
REQ-021 There is no back-to-back issue: in_ready SHALL rise the cycle after result transfer, so the minimum issue interval is N+2 cycles.
REQ-022 s and the flags SHALL update only on the transition to DONE; intermediate chunks are not visible on s.

Reset
REQ-023 While rst_n=0, including mid-BUSY or mid-DONE:
- State SHALL be IDLE.
- out_valid, s, n, z, c, v and the stored flag register SHALL be 0.
- in_ready SHALL be 1.
- Any in-flight operation SHALL be discarded.

Configuration
REQ-024 Macro ADDSUB_FLAG_REG_EN.
- Defined: a persistent NZCV register SHALL load with each result and persist across operations. use_cflag=1 SHALL select stored C as cin in place of c_in.
- Undefined: no persistent register; use_cflag SHALL be ignored and cin = c_in.

Structure
REQ-025 Package addsub_pkg SHALL hold:
- The FSM state enum (IDLE, BUSY, DONE).
- The op encodings OP_ADD=0 and OP_SUB=1.
- The flag-vector typedef nzcv_t.
REQ-026 A sub-module addsub_chunk SHALL implement one combinational CHUNK-bit slice: inputs x, y_eff and cin; outputs sum, cout and carry-into-MSB. The top SHALL instantiate it once and reuse it per cycle.

Verification (WIDTH=32, CHUNK=8)
REQ-027 Add: a=0x80000000, b=0x7FFFFFFF, op=0, c_in=0, rev=0 -> after 4 cycles s=0xFFFFFFFF, n=1, z=0, c=0, v=0.
REQ-028 Subtract: same a and b, op=1, c_in=1, rev=0 -> s=0x00000001, n=0, z=0, c=1, v=1. Repeat with rev=1 -> s=0xFFFFFFFF, n=1, z=0, c=0, v=1.
REQ-029 Zero result: a=b=0x12345678, op=1, c_in=1 -> s=0, z=1, c=1, v=0, n=0.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid meanwhile -> s and flags stay stable, in_ready=0, no second accept. Then out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
REQ-031 Reset: assert rst_n=0 in BUSY cycle 2 -> out_valid=0, s=0, flags=0, in_ready=1. A new request after release completes normally.
REQ-032 With ADDSUB_FLAG_REG_EN defined: add 0xFFFFFFFF+0x00000001, c_in=0 -> c=1. Then a=b=0, op=0, c_in=0, use_cflag=1 -> s=0x00000001. Without the macro, the same sequence -> s=0.

Source files
------------

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the chunk-serial adder/subtractor:
//   state_t   FSM state encoding (IDLE, BUSY, DONE)
//   OP_ADD / OP_SUB  op input encodings
//   nzcv_t    packed negative/zero/carry/overflow flag vector
//   overflow_flag()  signed overflow from MSB carry-in / carry-out
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Signed overflow: the carry into the MSB disagrees with the carry out of it.
  function automatic logic overflow_flag(input logic carry_msb, input logic carry_out);
    return carry_msb ^ carry_out;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational CHUNK-bit add slice used once per cycle by the serial unit.
// Ports:
//   x      [CHUNK-1:0] in   first operand slice
//   y_eff  [CHUNK-1:0] in   second operand slice (already inverted for subtract)
//   cin                in   carry into bit 0 of the slice
//   sum    [CHUNK-1:0] out  slice sum
//   cout               out  carry out of the slice MSB
//   cmsb               out  carry into the slice MSB (for overflow detection)
// -----------------------------------------------------------------------------
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y_eff,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] total_s;

  // Widened add keeps the carry out; the carry into the MSB is recovered
  // from the MSB sum bit since sum = x ^ y ^ carry_in at every position.
  always_comb begin
    total_s = {1'b0, x} + {1'b0, y_eff} + {{CHUNK{1'b0}}, cin};
    sum     = total_s[CHUNK-1:0];
    cout    = total_s[CHUNK];
    cmsb    = total_s[CHUNK-1] ^ x[CHUNK-1] ^ y_eff[CHUNK-1];
  end

endmodule

// File: rtl/addsub_serial_unit.sv
// -----------------------------------------------------------------------------
// addsub_serial_unit
// Chunk-serial WIDTH-bit adder/subtractor with NZCV flags. One CHUNK-bit slice
// is processed per cycle, LSB first, with a registered inter-chunk carry.
// Build option: define ADDSUB_FLAG_REG_EN to let use_cflag pick the stored C
// flag as carry-in; otherwise use_cflag is ignored.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   a, b [WIDTH-1:0]         operands (sampled on accept)
//   c_in, op, rev, use_cflag carry-in, 0=add/1=sub, operand swap, C-flag select
//   in_valid / in_ready      request handshake (ready only in IDLE)
//   out_valid / out_ready    result handshake
//   s [WIDTH-1:0]            result, n/z/c/v flags (all registered)
// -----------------------------------------------------------------------------
module addsub_serial_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op,
  input  logic             rev,
  input  logic             use_cflag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic               carry_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   s_r;
  nzcv_t              flags_r;
  logic               out_valid_r;
  logic               in_ready_r;

  logic [WIDTH-1:0]   x_sel_s;
  logic [WIDTH-1:0]   y_sel_s;
  logic [WIDTH-1:0]   y_eff_sel_s;
  logic               cin_sel_s;
  logic               accept_s;
  logic               last_chunk_s;
  int                 base_s;
  logic [CHUNK-1:0]   sum_s;
  logic               cout_s;
  logic               cmsb_s;
  logic [WIDTH-1:0]   result_s;
  nzcv_t              flags_next_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign n         = flags_r.n;
  assign z         = flags_r.z;
  assign c         = flags_r.c;
  assign v         = flags_r.v;

  assign accept_s     = in_valid && in_ready_r;
  assign last_chunk_s = (cnt_r == CNT_W'(N - 1));
  assign base_s       = int'(cnt_r) * CHUNK;

  // Operand routing: optional swap, inversion for subtract, carry-in source.
  always_comb begin
    if (rev) begin
      x_sel_s = b;
      y_sel_s = a;
    end else begin
      x_sel_s = a;
      y_sel_s = b;
    end
    if (op == OP_SUB) begin
      y_eff_sel_s = ~y_sel_s;
    end else begin
      y_eff_sel_s = y_sel_s;
    end
`ifdef ADDSUB_FLAG_REG_EN
    if (use_cflag) begin
      cin_sel_s = flags_r.c;
    end else begin
      cin_sel_s = c_in;
    end
`else
    cin_sel_s = c_in;
`endif
  end

`ifndef ADDSUB_FLAG_REG_EN
  // use_cflag has no effect in this build.
  logic unused_use_cflag_s;
  assign unused_use_cflag_s = use_cflag;
`endif

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x     (x_r[base_s +: CHUNK]),
    .y_eff (y_r[base_s +: CHUNK]),
    .cin   (carry_r),
    .sum   (sum_s),
    .cout  (cout_s),
    .cmsb  (cmsb_s)
  );

  // Merge the current slice into the partial result and derive final flags;
  // on the last chunk cout/cmsb are the word MSB carries.
  always_comb begin
    result_s                   = acc_r;
    result_s[base_s +: CHUNK]  = sum_s;
    flags_next_s.n             = result_s[WIDTH-1];
    flags_next_s.z             = (result_s == {WIDTH{1'b0}});
    flags_next_s.c             = cout_s;
    flags_next_s.v             = overflow_flag(cmsb_s, cout_s);
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (last_chunk_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, result and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      x_r         <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      flags_r     <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      // in_ready tracks the registered state exactly.
      in_ready_r <= (state_next_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r     <= x_sel_s;
            y_r     <= y_eff_sel_s;
            carry_r <= cin_sel_s;
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
          end
        end
        BUSY: begin
          acc_r   <= result_s;
          carry_r <= cout_s;
          if (last_chunk_s) begin
            s_r         <= result_s;
            flags_r     <= flags_next_s;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_unit.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial_unit
// Directed self-checking bench for addsub_serial_unit (WIDTH=32, CHUNK=8).
// Honours ADDSUB_FLAG_REG_EN for the stored-carry expectations.
// -----------------------------------------------------------------------------
module tb_addsub_serial_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        op;
  logic        rev;
  logic        use_cflag;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        n;
  logic        z;
  logic        c;
  logic        v;

  int total;
  int bad;

  addsub_serial_unit #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op        (op),
    .rev       (rev),
    .use_cflag (use_cflag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .n         (n),
    .z         (z),
    .c         (c),
    .v         (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] exp_s, input logic [3:0] exp_nzcv);
    chk({tag, "_s"}, {32'd0, s}, {32'd0, exp_s});
    chk({tag, "_nzcv"}, {60'd0, n, z, c, v}, {60'd0, exp_nzcv});
  endtask

  // Issue one request and wait (bounded) for out_valid; checks BUSY
  // behaviour, hidden intermediate results and the N=4 latency.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic icin, input logic iop, input logic irev, input logic iucf);
    int          lat;
    int          k;
    logic [31:0] prev;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    chk({tag, "_idle_rdy"}, {63'd0, in_ready}, 64'd1);
    prev      = s;
    a         = ia;
    b         = ib;
    c_in      = icin;
    op        = iop;
    rev       = irev;
    use_cflag = iucf;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk({tag, "_busy_rdy"}, {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      chk({tag, "_hidden"}, {32'd0, s}, {32'd0, prev});
      cyc();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_rdy_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    c_in      = 1'b0;
    op        = 1'b0;
    rev       = 1'b0;
    use_cflag = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_rdy", {63'd0, in_ready}, 64'd1);
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk_res("rst", 32'h0000_0000, 4'b0000);
    rst_n = 1'b1;
    cyc();

    // 0x80000000 + 0x7FFFFFFF
    run_op("add", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_res("add", 32'hFFFF_FFFF, 4'b1000);
    take_result("add");

    // 0x80000000 - 0x7FFFFFFF, no borrow
    run_op("sub", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_res("sub", 32'h0000_0001, 4'b0011);
    take_result("sub");

    // swapped: 0x7FFFFFFF - 0x80000000
    run_op("subrev", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_res("subrev", 32'hFFFF_FFFF, 4'b1001);
    take_result("subrev");

    // x - x = 0
    run_op("zero", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_res("zero", 32'h0000_0000, 4'b0110);
    take_result("zero");

    // 5 - 7 -> borrow
    run_op("borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_res("borrow", 32'hFFFF_FFFE, 4'b1000);
    take_result("borrow");

    // inter-chunk carry, then backpressure with in_valid pulses
    run_op("chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_res("chain", 32'h0000_0100, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      a        = 32'hDEAD_BEEF;
      in_valid = ~in_valid;
      cyc();
      chk("bp_ov", {63'd0, out_valid}, 64'd1);
      chk("bp_rdy", {63'd0, in_ready}, 64'd0);
      chk_res("bp", 32'h0000_0100, 4'b0000);
    end
    in_valid = 1'b0;
    take_result("bp");
    for (int i = 0; i < 6; i++) begin
      cyc();
    end
    chk("bp_no_second", {63'd0, out_valid}, 64'd0);
    chk("bp_idle_rdy", {63'd0, in_ready}, 64'd1);

    // reset during BUSY cycle 2
    a        = 32'h1111_1111;
    b        = 32'h2222_2222;
    c_in     = 1'b0;
    op       = 1'b0;
    rev      = 1'b0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", {63'd0, out_valid}, 64'd0);
    chk("mrst_rdy", {63'd0, in_ready}, 64'd1);
    chk_res("mrst", 32'h0000_0000, 4'b0000);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_op("post", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_res("post", 32'h2345_678A, 4'b0000);
    take_result("post");

    // stored carry flag as carry-in
    run_op("cset", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_res("cset", 32'h0000_0000, 4'b0110);
    take_result("cset");
    run_op("cuse", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ADDSUB_FLAG_REG_EN
    chk_res("cuse", 32'h0000_0001, 4'b0000);
`else
    chk_res("cuse", 32'h0000_0000, 4'b0100);
`endif
    take_result("cuse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
